// File: rtl/mul_shift_add.sv
// Multi-cycle unsigned shift-and-add multiplier: one ripple-carry add and one shift per CALC cycle.
// Optional macro MUL_ZERO_SKIP_EN: a zero operand goes straight to DONE with a zero product.
module mul_shift_add #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH:0]       carry;
    logic [2*WIDTH-1:0]   step_sh;

    // Ripple chain of add_1 cells: acc + (q[0] ? m : 0), carry-in 0.
    assign addend   = q_q[0] ? m_q : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_add_1
        assign sum[i]     = acc_q[i] ^ addend[i] ^ carry[i];
        assign carry[i+1] = (acc_q[i] & addend[i]) | (carry[i] & (acc_q[i] ^ addend[i]));
    end

    // {cout, sum, q} shifted right by one; the carry lands in the acc MSB.
    if (WIDTH > 1) begin : g_shift_wide
        assign step_sh = {carry[WIDTH], sum, q_q[WIDTH-1:1]};
    end else begin : g_shift_narrow
        assign step_sh = {carry[WIDTH], sum};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d   = in_a;
                    q_d   = in_b;
                    acc_d = '0;
                    cnt_d = '0;
`ifdef MUL_ZERO_SKIP_EN
                    if ((in_a == '0) || (in_b == '0)) begin
                        prod_d  = '0;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                acc_d = step_sh[2*WIDTH-1:WIDTH];
                q_d   = step_sh[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    prod_d  = step_sh;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CALC);
    assign out_valid = (state_q == DONE);
    assign prod      = prod_q;

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add: directed cases, reset abort, and an operand sweep with random stalls.
module tb_mul_shift_add;

    localparam int WIDTH = 4;
`ifdef MUL_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] prod;
    logic               busy;

    int errs   = 0;
    int checks = 0;
    int hs_viol = 0;

    mul_shift_add #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status decodes are one-hot: never two of IDLE/CALC/DONE at once.
    always @(negedge clk) begin
        if (rst_n && ((in_ready && out_valid) || (in_ready && busy) || (busy && out_valid)))
            hs_viol++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One full transaction judged against a*b and the expected timing.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int stall, input bit hold_v);
        int lat;
        int bsy;
        int exp_lat;
        logic [2*WIDTH-1:0] exp_p;
        exp_p   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        exp_lat = (SKIP && (a == 0 || b == 0)) ? 0 : WIDTH;

        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq("ready_before_accept", 32'(in_ready), 32'd1);

        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        if (hold_v) begin
            in_a = WIDTH'($urandom);
            in_b = WIDTH'($urandom);
        end else begin
            in_valid = 1'b0;
        end

        lat = 0;
        bsy = 0;
        while (!out_valid && lat < 100) begin
            bsy = bsy + int'(busy);
            lat++;
            @(negedge clk);
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("busy_cycles", 32'(bsy), 32'(exp_lat));
        check_eq("prod", 32'(prod), 32'(exp_p));

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_prod", 32'(prod), 32'(exp_p));
            check_eq("hold_no_ready", 32'(in_ready), 32'd0);
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("release_valid_low", 32'(out_valid), 32'd0);
        check_eq("release_idle", 32'(in_ready), 32'd1);
        check_eq("release_prod_kept", 32'(prod), 32'(exp_p));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_prod", 32'(prod), 32'd0);

        run_op(4'd13, 4'd11, 0, 1'b0);
        run_op(4'd15, 4'd15, 0, 1'b0);
        run_op(4'd9,  4'd7,  6, 1'b0);
        run_op(4'd2,  4'd3,  0, 1'b0);
        run_op(4'd0,  4'd9,  0, 1'b0);
        run_op(4'd6,  4'd0,  2, 1'b1);

        // Reset two steps into a 12*5 operation.
        in_a = 4'd12;
        in_b = 4'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_no_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_prod", 32'(prod), 32'd0);
        check_eq("abort_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        check_eq("abort_still_no_valid", 32'(out_valid), 32'd0);
        run_op(4'd3, 4'd3, 0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(WIDTH'(a), WIDTH'(b), int'($urandom_range(0, 3)), 1'($urandom));
            end
        end

        check_eq("handshake_exclusive", 32'(hs_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not complete, errors=%0d", errs);
        $fatal(1, "timeout");
    end

endmodule
